// File: rtl/vstore_bank_sequencer_if.sv
// Request/response bundle between the execute stage and vstore_bank_sequencer.
// master = execute stage issuing stores, slave = the store unit.
interface vstore_bank_sequencer_if #(
  parameter int NUM_LANES = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_vec;
  logic [1:0]             store_select;
  logic [31:0]            s_addr;
  logic [31:0]            s_data;
  logic [NUM_LANES-1:0]   v_mask;
  logic [NUM_LANES*32-1:0] v_addr;
  logic [NUM_LANES*32-1:0] v_data;
  logic                   done;
  logic                   misalign;

  modport master (
    output req_valid, req_vec, store_select, s_addr, s_data, v_mask, v_addr, v_data,
    input  req_ready, done, misalign
  );

  modport slave (
    input  req_valid, req_vec, store_select, s_addr, s_data, v_mask, v_addr, v_data,
    output req_ready, done, misalign
  );
endinterface

// File: rtl/vstore_bank_sequencer.sv
// Registered scalar/vector store unit feeding NUM_BANKS data-memory banks; conflicting lanes drain
// lowest-lane-first. Define STORE_MISALIGN_TRAP_EN to flag misaligned scalar stores on misalign.
module vstore_bank_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int NUM_BANKS = 4,
  parameter int ROW_W     = 10
) (
  input  logic                       clk,
  input  logic                       nrst,
  vstore_bank_sequencer_if.slave     req,
  output logic [NUM_BANKS*4-1:0]     bank_we,
  output logic [NUM_BANKS*ROW_W-1:0] bank_addr,
  output logic [NUM_BANKS*32-1:0]    bank_data
);
  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int KEY_W     = ROW_W + BANK_BITS;
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [BANK_BITS-1:0] BANK_MASK = BANK_BITS'(NUM_BANKS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCALAR = 2'd1;
  localparam logic [1:0] ST_VDRAIN = 2'd2;

  logic [1:0]           state_reg;
  logic [NUM_LANES-1:0] pend_reg;
  logic [KEY_W-1:0]     lane_key_reg [NUM_LANES];
  logic [31:0]          lane_data_reg [NUM_LANES];
  logic [3:0]           we_reg [NUM_BANKS];
  logic [ROW_W-1:0]     addr_reg [NUM_BANKS];
  logic [31:0]          data_reg [NUM_BANKS];
  logic                 done_reg;
`ifdef STORE_MISALIGN_TRAP_EN
  logic                 misalign_reg;
`endif

  // Grant sources: live inputs on the accept edge, latched lanes while draining.
  logic                 is_idle;
  logic [NUM_LANES-1:0] src_pend;
  logic [KEY_W-1:0]     src_key [NUM_LANES];
  logic [31:0]          src_data [NUM_LANES];

  assign is_idle  = (state_reg == ST_IDLE);
  assign src_pend = is_idle ? req.v_mask : pend_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_src
      assign src_key[gi]  = is_idle ? req.v_addr[32*gi+2 +: KEY_W] : lane_key_reg[gi];
      assign src_data[gi] = is_idle ? req.v_data[32*gi +: 32] : lane_data_reg[gi];
    end
  endgenerate

  logic              bank_hit [NUM_BANKS];
  logic [LANE_W-1:0] bank_sel [NUM_BANKS];

  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_grant
      logic              hit;
      logic [LANE_W-1:0] sel;
      // Scan downward so the lowest-index pending lane wins the bank.
      always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int li = NUM_LANES - 1; li >= 0; li--) begin
          if (src_pend[li] && ((src_key[li][BANK_BITS-1:0] & BANK_MASK) == BANK_BITS'(gi))) begin
            hit = 1'b1;
            sel = LANE_W'(li);
          end
        end
      end
      assign bank_hit[gi] = hit;
      assign bank_sel[gi] = sel;

      assign bank_we[4*gi +: 4]         = we_reg[gi];
      assign bank_addr[ROW_W*gi +: ROW_W] = addr_reg[gi];
      assign bank_data[32*gi +: 32]     = data_reg[gi];
    end
  endgenerate

  logic [NUM_LANES-1:0] gnt_all;
  logic [NUM_LANES-1:0] rem_pend;
  logic                 drive_gnt;

  always_comb begin
    gnt_all = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_hit[b]) gnt_all[bank_sel[b]] = 1'b1;
    end
  end

  assign rem_pend  = src_pend & ~gnt_all;
  assign drive_gnt = (is_idle && req.req_valid && req.req_vec && (|req.v_mask)) ||
                     ((state_reg == ST_VDRAIN) && (|pend_reg));

  logic [1:0]           s_off;
  logic [3:0]           s_be;
  logic [31:0]          s_wdata;
  logic [BANK_BITS-1:0] s_bank;
  logic [ROW_W-1:0]     s_row;

  // Byte-enable bit 3 is the least significant byte lane; unsupported size/offset pairs enable nothing.
  always_comb begin
    s_off   = req.s_addr[1:0];
    s_bank  = req.s_addr[BANK_BITS+1:2] & BANK_MASK;
    s_row   = req.s_addr[KEY_W+1:BANK_BITS+2];
    s_be    = 4'b0000;
    s_wdata = '0;
    case (req.store_select)
      2'd0: begin
        s_be    = 4'b1000 >> s_off;
        s_wdata = {24'd0, req.s_data[7:0]} << {s_off, 3'b000};
      end
      2'd1: if (!s_off[0]) begin
        s_be    = s_off[1] ? 4'b0011 : 4'b1100;
        s_wdata = {16'd0, req.s_data[15:0]} << {s_off, 3'b000};
      end
      2'd2: if (s_off == 2'd0) begin
        s_be    = 4'b1111;
        s_wdata = req.s_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= ST_IDLE;
      pend_reg  <= '0;
      done_reg  <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      misalign_reg <= 1'b0;
`endif
      for (int b = 0; b < NUM_BANKS; b++) begin
        we_reg[b]   <= '0;
        addr_reg[b] <= '0;
        data_reg[b] <= '0;
      end
      for (int l = 0; l < NUM_LANES; l++) begin
        lane_key_reg[l]  <= '0;
        lane_data_reg[l] <= '0;
      end
    end else begin
      done_reg <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      misalign_reg <= 1'b0;
`endif
      for (int b = 0; b < NUM_BANKS; b++) we_reg[b] <= '0;

      case (state_reg)
        ST_IDLE: begin
          if (req.req_valid && !req.req_vec) begin
            state_reg <= ST_SCALAR;
            done_reg  <= 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
            misalign_reg <= (s_be == 4'b0000);
`endif
            for (int b = 0; b < NUM_BANKS; b++) begin
              if ((s_be != 4'b0000) && (BANK_BITS'(b) == s_bank)) begin
                we_reg[b]   <= s_be;
                addr_reg[b] <= s_row;
                data_reg[b] <= s_wdata;
              end
            end
          end else if (req.req_valid && (|req.v_mask)) begin
            state_reg <= ST_VDRAIN;
            for (int l = 0; l < NUM_LANES; l++) begin
              lane_key_reg[l]  <= src_key[l];
              lane_data_reg[l] <= src_data[l];
            end
          end
        end
        ST_SCALAR: state_reg <= ST_IDLE;
        ST_VDRAIN: if (!(|pend_reg)) state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase

      // The cycle whose grants leave nothing pending is the final write cycle.
      if (drive_gnt) begin
        pend_reg <= rem_pend;
        done_reg <= ~(|rem_pend);
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (bank_hit[b]) begin
            we_reg[b]   <= 4'b1111;
            addr_reg[b] <= src_key[bank_sel[b]][KEY_W-1:BANK_BITS];
            data_reg[b] <= src_data[bank_sel[b]];
          end
        end
      end
    end
  end

  assign req.req_ready = is_idle;
  assign req.done      = done_reg;
`ifdef STORE_MISALIGN_TRAP_EN
  assign req.misalign  = misalign_reg;
`else
  assign req.misalign  = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req.s_addr, req.v_addr};
endmodule
